// File: rtl/key3_pkg.sv
// key3_test shared definitions: tap count, coefficient/sum widths, types.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package key3_pkg;

  localparam int NTAPS = 8;
  localparam int CW    = 16;
  localparam int SW    = CW + 3;          // wide enough for 8 signed CW-bit terms
  localparam int PTR_W = $clog2(NTAPS);

  typedef logic signed [CW-1:0] coeff_t;
  typedef coeff_t [NTAPS-1:0]   coeff_arr_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam coeff_t COEFF_RST = 16'sd1;  // all-ones taps = 8-sample majority

  // Sign-extend one coefficient into the accumulator width.
  function automatic sum_t sext(input coeff_t c);
    sum_t r;
    r = c;
    return r;
  endfunction

endpackage

// File: rtl/key3_if.sv
// key3_test channel bus: raw samples and coefficient load in, filtered samples out.
// Latency: n/a (wiring only).
// Backpressure: none; coeff_load is a write strobe with no ready/ack.
// Ports: pulse_in[WIDTH], filter_coeff (signed CW), coeff_load, pulse_out[WIDTH].
interface key3_if
  import key3_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pulse_in;
  coeff_t           filter_coeff;
  logic             coeff_load;
  logic [WIDTH-1:0] pulse_out;

  modport master (
    output pulse_in, filter_coeff, coeff_load,
    input  pulse_out
  );

  modport slave (
    input  pulse_in, filter_coeff, coeff_load,
    output pulse_out
  );
endinterface

// File: rtl/key3_channel.sv
// One debounce channel: 8-deep sample history, weighted sum, registered compare.
// Latency: sample captured at edge n affects o_pulse at edge n+1.
// Backpressure: none; consumes one sample every clock.
// Ports: i_clk, i_rst (sync, active-high), i_pulse, i_coeff (shared taps),
//        i_thresh (shared threshold), o_pulse (registered output).
module key3_channel
  import key3_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pulse,
  input  coeff_arr_t i_coeff,
  input  sum_t       i_thresh,
  output logic       o_pulse
);

  logic [NTAPS-1:0] r_hist;   // r_hist[0] is the newest sample
  logic             r_pulse;
  sum_t             w_sum;

  // History bits are 0/1, so each tap is a conditional add.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (r_hist[k]) begin
        w_sum = w_sum + sext(i_coeff[k]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_hist  <= {r_hist[NTAPS-2:0], i_pulse};
      r_pulse <= (w_sum > i_thresh);   // both signed: signed compare
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/key3_test_core.sv
// key3_test top: WIDTH debounce channels sharing one serially loaded tap set.
// Latency: pulse_in at edge n reaches pulse_out at edge n+1; a tap written
//          at edge n is used by the output registered at edge n+1.
// Backpressure: none; every cycle with coeff_load high writes one tap.
// Ports: clk_20m, rst_n (sync, ACTIVE-HIGH despite the name), bus (key3_if.slave).
module key3_test_core
  import key3_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic  clk_20m,
  input  logic  rst_n,
  key3_if.slave bus
);

  coeff_arr_t       r_coeff;
  logic [PTR_W-1:0] r_ptr;
  sum_t             w_csum;
  sum_t             w_thresh;
  logic [WIDTH-1:0] w_pulse_out;

  // Write pointer wraps mod NTAPS inside a burst and rewinds whenever the
  // strobe drops, so every burst starts at tap 0.
  always_ff @(posedge clk_20m) begin
    if (rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_coeff[k] <= COEFF_RST;
      end
      r_ptr <= '0;
    end else if (bus.coeff_load) begin
      r_coeff[r_ptr] <= bus.filter_coeff;
      r_ptr          <= r_ptr + PTR_W'(1);
    end else begin
      r_ptr <= '0;
    end
  end

  // Threshold is half the tap total, floor-rounded by the arithmetic shift.
  always_comb begin
    w_csum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      w_csum = w_csum + sext(r_coeff[k]);
    end
    w_thresh = w_csum >>> 1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    key3_channel u_ch (
      .i_clk    (clk_20m),
      .i_rst    (rst_n),
      .i_pulse  (bus.pulse_in[g]),
      .i_coeff  (r_coeff),
      .i_thresh (w_thresh),
      .o_pulse  (w_pulse_out[g])
    );
  end

  assign bus.pulse_out = w_pulse_out;

endmodule

// File: tb/tb_key3_test_core.sv
module tb_key3_test_core;
  import key3_pkg::*;

  logic clk_20m = 1'b0;
  logic rst_n   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  key3_if #(.WIDTH(32)) u_if ();

  key3_test_core #(.WIDTH(32)) dut (
    .clk_20m (clk_20m),
    .rst_n   (rst_n),
    .bus     (u_if.slave)
  );

  always #25 clk_20m = ~clk_20m;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_20m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    u_if.coeff_load = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    coeff_t exp_c;
    sum_t   exp_t;
    exp_c = 16'sd1;
    exp_t = 19'sd4;
    rst_n = 1'b1;
    u_if.pulse_in     = 32'hFFFF_FFFF;
    u_if.coeff_load   = 1'b0;
    u_if.filter_coeff = '0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (u_if.pulse_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_out edge %0d: got %h want 00000000", e, u_if.pulse_out);
      end
    end
    for (int k = 0; k < NTAPS; k++) begin
      checks++;
      if (dut.r_coeff[k] !== exp_c) begin
        errors++;
        $display("FAIL reset_coeff[%0d]: got %0d want 1", k, dut.r_coeff[k]);
      end
    end
    checks++;
    if (dut.w_thresh !== exp_t) begin
      errors++;
      $display("FAIL reset_thresh: got %0d want 4", dut.w_thresh);
    end
    checks++;
    if (dut.r_ptr !== 3'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr);
    end
  endtask

  task automatic test_default_majority();
    logic [31:0] exp;
    rst_n = 1'b0;
    u_if.pulse_in = 32'hAAAA_AAAA;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e >= 6) ? 32'hAAAA_AAAA : 32'h0;
      checks++;
      if (u_if.pulse_out !== exp) begin
        errors++;
        $display("FAIL majority edge %0d: got %h want %h", e, u_if.pulse_out, exp);
      end
    end
  endtask

  task automatic test_serial_load();
    coeff_t vals [8];
    sum_t   exp_t;
    vals = '{16'sd0, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    exp_t = 19'sd3;
    u_if.coeff_load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      u_if.filter_coeff = vals[i];
      tick();
    end
    u_if.coeff_load = 1'b0;
    tick();
    for (int k = 0; k < NTAPS; k++) begin
      checks++;
      if (dut.r_coeff[k] !== vals[k]) begin
        errors++;
        $display("FAIL load_coeff[%0d]: got %0d want %0d", k, dut.r_coeff[k], vals[k]);
      end
    end
    checks++;
    if (dut.w_thresh !== exp_t) begin
      errors++;
      $display("FAIL load_thresh: got %0d want 3", dut.w_thresh);
    end
    checks++;
    if (dut.r_ptr !== 3'd0) begin
      errors++;
      $display("FAIL load_ptr: got %0d want 0", dut.r_ptr);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (u_if.pulse_out !== 32'hAAAA_AAAA) begin
        errors++;
        $display("FAIL load_filter edge %0d: got %h want aaaaaaaa", e, u_if.pulse_out);
      end
    end
  endtask

  task automatic test_glitch(input int len);
    logic exp;
    do_reset();
    u_if.pulse_in = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    u_if.pulse_in = 32'h1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == len) u_if.pulse_in = 32'h0;
      exp = (len == 5) && (e >= 6) && (e <= 9);
      checks++;
      if (u_if.pulse_out[0] !== exp) begin
        errors++;
        $display("FAIL glitch_len%0d edge %0d: got %b want %b", len, e, u_if.pulse_out[0], exp);
      end
    end
  endtask

  task automatic test_negative_taps();
    logic [31:0] exp;
    sum_t        exp_t;
    exp_t = -19'sd4;
    do_reset();
    u_if.pulse_in     = 32'h0;
    u_if.coeff_load   = 1'b1;
    u_if.filter_coeff = -16'sd1;
    // After k writes the tap total is 8-2k, so T=4-k; zero history beats T from k=5,
    // visible one edge after that write.
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = (e >= 6) ? 32'hFFFF_FFFF : 32'h0;
      checks++;
      if (u_if.pulse_out !== exp) begin
        errors++;
        $display("FAIL neg_load edge %0d: got %h want %h", e, u_if.pulse_out, exp);
      end
    end
    u_if.coeff_load = 1'b0;
    u_if.pulse_in   = 32'hFFFF_FFFF;
    checks++;
    if (dut.w_thresh !== exp_t) begin
      errors++;
      $display("FAIL neg_thresh: got %0d want -4", dut.w_thresh);
    end
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e <= 4) ? 32'hFFFF_FFFF : 32'h0;
      checks++;
      if (u_if.pulse_out !== exp) begin
        errors++;
        $display("FAIL neg_fill edge %0d: got %h want %h", e, u_if.pulse_out, exp);
      end
    end
  endtask

  task automatic test_wrap_and_midload_reset();
    coeff_t exp_c;
    do_reset();
    u_if.coeff_load = 1'b1;
    for (int i = 0; i < 9; i++) begin
      u_if.filter_coeff = coeff_t'(10 + i);
      tick();
    end
    checks++;
    if (dut.r_ptr !== 3'd1) begin
      errors++;
      $display("FAIL wrap_ptr: got %0d want 1", dut.r_ptr);
    end
    u_if.coeff_load = 1'b0;
    tick();
    exp_c = 16'sd18;
    checks++;
    if (dut.r_coeff[0] !== exp_c) begin
      errors++;
      $display("FAIL wrap_c0: got %0d want 18", dut.r_coeff[0]);
    end
    exp_c = 16'sd11;
    checks++;
    if (dut.r_coeff[1] !== exp_c) begin
      errors++;
      $display("FAIL wrap_c1: got %0d want 11", dut.r_coeff[1]);
    end
    checks++;
    if (dut.r_ptr !== 3'd0) begin
      errors++;
      $display("FAIL wrap_ptr_drop: got %0d want 0", dut.r_ptr);
    end

    // Three writes, then reset while the strobe is still high.
    u_if.coeff_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.filter_coeff = coeff_t'(-5 - i);
      tick();
    end
    rst_n = 1'b1;
    tick();
    exp_c = 16'sd1;
    for (int k = 0; k < NTAPS; k++) begin
      checks++;
      if (dut.r_coeff[k] !== exp_c) begin
        errors++;
        $display("FAIL midreset_coeff[%0d]: got %0d want 1", k, dut.r_coeff[k]);
      end
    end
    checks++;
    if (dut.r_ptr !== 3'd0) begin
      errors++;
      $display("FAIL midreset_ptr: got %0d want 0", dut.r_ptr);
    end
    u_if.coeff_load = 1'b0;
    rst_n = 1'b0;
  endtask

  initial begin
    u_if.pulse_in     = '0;
    u_if.filter_coeff = '0;
    u_if.coeff_load   = 1'b0;
    #3;
    test_reset();
    test_default_majority();
    test_serial_load();
    test_glitch(4);
    test_glitch(5);
    test_negative_taps();
    test_wrap_and_midload_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
